// File: rtl/effect_ctrl_pkg.sv
// Shared types and constants for the effect parameter controller.
package effect_ctrl_pkg;

  localparam int LVL_W = 3;
  localparam logic [LVL_W-1:0] LVL_MAX = 3'd7;
  localparam int NUM_FX_DEF = 4;

  typedef enum logic {
    IDLE,
    EDIT
  } ctrl_state_t;

  // Saturating one-step level change: up when i_up is set, otherwise down.
  function automatic logic [LVL_W-1:0] lvl_step(input logic [LVL_W-1:0] lvl, input logic up);
    if (up) return (lvl == LVL_MAX) ? lvl : lvl + LVL_W'(1);
    else    return (lvl == '0) ? lvl : lvl - LVL_W'(1);
  endfunction

endpackage

// File: rtl/key_press_gen.sv
// Key press detector: registers a debounced key level, emits a one-cycle step
// pulse on each rising edge and, when REPEAT_EN is set, auto-repeat steps while held.
module key_press_gen #(
  parameter bit          REPEAT_EN     = 1'b0,
  parameter logic [23:0] REPEAT_DELAY  = 24'd6_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd1_500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  input  logic i_rep_en,
  input  logic i_block,
  output logic o_step,
  output logic o_held
);

  logic        r_key;
  logic        r_key_q;
  logic        r_armed;
  logic [23:0] r_rep_cnt;
  logic        w_press;
  logic        w_hold;
  logic        w_rep;

  assign w_press = r_key & ~r_key_q;
  assign w_hold  = REPEAT_EN && i_rep_en && !i_block && r_key && r_key_q;
  // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD.
  assign w_rep   = w_hold && (r_armed ? (r_rep_cnt == REPEAT_PERIOD - 24'd1)
                                      : (r_rep_cnt == REPEAT_DELAY - 24'd1));
  assign o_step  = w_press | w_rep;
  assign o_held  = r_key;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key     <= 1'b0;
      r_key_q   <= 1'b0;
      r_armed   <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_key   <= i_key;
      r_key_q <= r_key;
      if (!w_hold) begin
        r_rep_cnt <= '0;
        r_armed   <= 1'b0;
      end else if (w_rep) begin
        r_rep_cnt <= '0;
        r_armed   <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 24'd1;
      end
    end
  end

endmodule

// File: rtl/effect_ctrl.sv
// Effect parameter controller: key-driven level editing with per-sample commit.
// Define EFFECT_CTRL_AUTOREPEAT_EN to enable up/down auto-repeat while held.
module effect_ctrl
  import effect_ctrl_pkg::*;
#(
  parameter int          NUM_FX         = NUM_FX_DEF,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter logic [23:0] REPEAT_DELAY   = 24'd6_000_000,
  parameter logic [23:0] REPEAT_PERIOD  = 24'd1_500_000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic                       i_key_sel,
  input  logic                       i_key_up,
  input  logic                       i_key_down,
  input  logic [NUM_FX-1:0]          i_sw_en,
  output logic [$clog2(NUM_FX)-1:0]  o_sel,
  output logic                       o_editing,
  output logic [LVL_W-1:0]           o_level_cur,
  output logic [NUM_FX*LVL_W-1:0]    o_level,
  output logic [NUM_FX-1:0]          o_enable
);

  localparam int SEL_W = $clog2(NUM_FX);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FX - 1);

`ifdef EFFECT_CTRL_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  ctrl_state_t              r_state;
  logic                     r_editing;
  logic [SEL_W-1:0]         r_sel;
  logic [23:0]              r_idle_cnt;
  logic [LVL_W-1:0]         r_shadow [NUM_FX];
  logic [NUM_FX-1:0]        r_sw_s1;
  logic [NUM_FX-1:0]        r_sw_s2;
  logic [NUM_FX*LVL_W-1:0]  r_level;
  logic [NUM_FX-1:0]        r_enable;

  logic w_sel_step, w_up_step, w_dn_step;
  logic w_sel_held, w_up_held, w_dn_held;
  logic w_lvl_step;

  // Sel never repeats; its held level loops into its own (inactive) block input.
  key_press_gen #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_key_sel (
    .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key_sel), .i_rep_en(1'b0),
    .i_block(w_sel_held), .o_step(w_sel_step), .o_held(w_sel_held)
  );

  key_press_gen #(.REPEAT_EN(AUTOREP), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_key_up (
    .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key_up), .i_rep_en(r_editing),
    .i_block(w_dn_held), .o_step(w_up_step), .o_held(w_up_held)
  );

  key_press_gen #(.REPEAT_EN(AUTOREP), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_key_dn (
    .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key_down), .i_rep_en(r_editing),
    .i_block(w_up_held), .o_step(w_dn_step), .o_held(w_dn_held)
  );

  assign w_lvl_step = w_up_step ^ w_dn_step;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_editing  <= 1'b0;
      r_sel      <= '0;
      r_idle_cnt <= '0;
      for (int unsigned k = 0; k < NUM_FX; k++) r_shadow[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_step) begin
            r_state    <= EDIT;
            r_editing  <= 1'b1;
            r_idle_cnt <= '0;
          end
        end
        EDIT: begin
          // Sel wins over up/down; any accepted event postpones the timeout.
          if (w_sel_step) begin
            r_sel      <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
            r_idle_cnt <= '0;
          end else if (w_lvl_step) begin
            r_shadow[r_sel] <= lvl_step(r_shadow[r_sel], w_up_step);
            r_idle_cnt      <= '0;
          end else if (r_idle_cnt == TIMEOUT_CYCLES - 24'd1) begin
            r_state    <= IDLE;
            r_editing  <= 1'b0;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_level  <= '0;
      r_enable <= '0;
    end else begin
      r_sw_s1 <= i_sw_en;
      r_sw_s2 <= r_sw_s1;
      if (i_valid) begin
        for (int unsigned k = 0; k < NUM_FX; k++) r_level[k*LVL_W +: LVL_W] <= r_shadow[k];
        r_enable <= r_sw_s2;
      end
    end
  end

  assign o_sel       = r_sel;
  assign o_editing   = r_editing;
  assign o_level_cur = r_shadow[r_sel];
  assign o_level     = r_level;
  assign o_enable    = r_enable;

endmodule

// File: tb/tb_effect_ctrl.sv
// Self-checking bench for effect_ctrl: key-press vector table plus a commit scoreboard.
module tb_effect_ctrl;

  localparam int NFX = 4;

`ifdef EFFECT_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic                clk;
  logic                rst = 1'b0;
  logic                valid = 1'b0;
  logic                ksel = 1'b0;
  logic                kup = 1'b0;
  logic                kdn = 1'b0;
  logic [NFX-1:0]      sw = '0;
  logic [1:0]          o_sel;
  logic                o_editing;
  logic [2:0]          o_level_cur;
  logic [NFX*3-1:0]    o_level;
  logic [NFX-1:0]      o_enable;

  effect_ctrl #(
    .NUM_FX(NFX), .TIMEOUT_CYCLES(24'd16), .REPEAT_DELAY(24'd8), .REPEAT_PERIOD(24'd4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_key_sel(ksel), .i_key_up(kup),
    .i_key_down(kdn), .i_sw_en(sw), .o_sel(o_sel), .o_editing(o_editing),
    .o_level_cur(o_level_cur), .o_level(o_level), .o_enable(o_enable)
  );

  typedef struct {
    logic s;
    logic u;
    logic d;
    int   es;
    logic ee;
    int   ec;
  } vec_t;

  vec_t              vecs[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                model [NFX];
  logic [NFX*3-1:0]  sb_q[$];
  logic [NFX*3-1:0]  exp_hold = '0;
  int                hold_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int vc = 0;
    forever begin
      @(negedge clk);
      vc++;
      valid = (vc % 5 == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NFX*3-1:0] model_pack();
    logic [NFX*3-1:0] r;
    logic [31:0] v;
    r = '0;
    for (int k = 0; k < NFX; k++) begin
      v = model[k];
      r[k*3 +: 3] = v[2:0];
    end
    return r;
  endfunction

  // Expected commit values enter at each strobe edge and are compared afterwards.
  always @(posedge clk) if (valid && !rst) sb_q.push_back(model_pack());

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_hold = '0;
    end else if (sb_q.size() > 0) begin
      exp_hold = sb_q.pop_front();
    end
    chk("o_level_sb", o_level, exp_hold);
  end

  function automatic void add(logic s, logic u, logic d, int es, logic ee, int ec);
    vec_t v;
    v.s = s; v.u = u; v.d = d; v.es = es; v.ee = ee; v.ec = ec;
    vecs.push_back(v);
  endfunction

  // Called at a negedge; one press, then checked after the update edge.
  task automatic apply(input vec_t v);
    ksel = v.s; kup = v.u; kdn = v.d;
    @(posedge clk); @(negedge clk);
    ksel = 1'b0; kup = 1'b0; kdn = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("o_sel", o_sel, v.es);
    chk("o_editing", o_editing, v.ee);
    chk("o_level_cur", o_level_cur, v.ec);
    model[v.es] = v.ec;
  endtask

  task automatic press(input logic s, input logic u, input logic d, input int es, input logic ee, input int ec);
    vec_t v;
    v.s = s; v.u = u; v.d = d; v.es = es; v.ee = ee; v.ec = ec;
    apply(v);
  endtask

  task automatic wait_commit();
    bit found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      if (valid) begin
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    chk("valid_seen", found, 1);
  endtask

  initial begin
    for (int k = 0; k < NFX; k++) model[k] = 0;

    // Table: idle up ignored, edit+commit, wrap, saturation, simultaneous keys.
    add(0,1,0, 0,0,0);
    add(1,0,0, 0,1,0);
    add(0,1,0, 0,1,1);
    add(0,1,0, 0,1,2);
    add(0,1,0, 0,1,3);
    add(1,0,0, 1,1,0);
    add(1,0,0, 2,1,0);
    add(1,0,0, 3,1,0);
    for (int i = 0; i < 9; i++) add(0,1,0, 3,1, (i + 1 > 7) ? 7 : i + 1);
    for (int i = 0; i < 9; i++) add(0,0,1, 3,1, (6 - i < 0) ? 0 : 6 - i);
    add(0,1,0, 3,1,1);
    add(0,1,0, 3,1,2);
    add(0,1,1, 3,1,2);
    add(1,1,0, 0,1,3);
    add(1,0,0, 1,1,0);
    add(1,0,0, 2,1,0);
    add(1,0,0, 3,1,2);
    add(1,0,0, 0,1,3);

    #1 rst = 1'b1;
    #2;
    chk("rst_sel", o_sel, 0);
    chk("rst_editing", o_editing, 0);
    chk("rst_level", o_level, 0);
    chk("rst_enable", o_enable, 0);
    chk("rst_cur", o_level_cur, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    // Timeout exactly 16 cycles after the last accepted event.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("timeout_pre", o_editing, 1);
      if (k == 16) chk("timeout", o_editing, 0);
    end

    // Extension: a second event 10 cycles later restarts the timeout.
    press(1,0,0, 0,1,3);
    repeat (8) @(negedge clk);
    press(0,1,0, 0,1,4);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("extend_pre", o_editing, 1);
      if (k == 16) chk("extend", o_editing, 0);
    end

    // Switch enables pass the synchronizer and commit on the next strobe.
    wait_commit();
    sw = 4'b1010;
    @(negedge clk);
    chk("enable_pre", o_enable, 4'b0000);
    wait_commit();
    chk("enable", o_enable, 4'b1010);

    // Held up key on effect 1.
    press(1,0,0, 0,1,4);
    press(1,0,0, 1,1,0);
    kup = 1'b1;
    for (int j = 0; j <= 22; j++) begin
      @(posedge clk); @(negedge clk);
      if (j == 1 || (AR && (j == 9 || j == 13 || j == 17 || j == 21))) model[1] = model[1] + 1;
      if (j == 21) kup = 1'b0;
      chk("hold_cur", o_level_cur, model[1]);
    end
    hold_exp = AR ? 5 : 1;
    chk("hold_level", o_level_cur, hold_exp);
    repeat (20) @(negedge clk);
    chk("hold_idle", o_editing, 0);

    // Async reset mid-edit with shadow[2]=5.
    press(1,0,0, 1,1,hold_exp);
    press(1,0,0, 2,1,0);
    for (int i = 1; i <= 5; i++) press(0,1,0, 2,1,i);
    wait_commit();
    chk("pre_rst_lvl2", o_level[8:6], 5);
    chk("pre_rst_enable", o_enable, 4'b1010);
    chk("pre_rst_editing", o_editing, 1);
    #2 rst = 1'b1;
    for (int k = 0; k < NFX; k++) model[k] = 0;
    #1;
    chk("arst_sel", o_sel, 0);
    chk("arst_editing", o_editing, 0);
    chk("arst_cur", o_level_cur, 0);
    chk("arst_level", o_level, 0);
    chk("arst_enable", o_enable, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_editing", o_editing, 0);
    press(1,0,0, 0,1,0);
    press(1,0,0, 1,1,0);
    press(1,0,0, 2,1,0);
    wait_commit();
    chk("post_rst_level", o_level, 0);
    chk("post_rst_enable", o_enable, 4'b1010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/effect_ctrl.md
# effect_ctrl

Parameter controller for the audio effects chain. It turns debounced push-key levels and enable switches into per-effect `level` (0–7) and `enable` values, and drives the `i_level` and `i_enable` inputs of the effect blocks. A two-state edit FSM handles key presses. Outputs change only on the sample strobe, so an effect never sees a parameter change mid-sample.

## Interface
- `NUM_FX`, 4: number of effects controlled (≥2).
- `TIMEOUT_CYCLES`, 24'd12_000_000: idle cycles in EDIT before returning to IDLE.
- `REPEAT_DELAY`, 24'd6_000_000: hold time before the first auto-repeat step (macro only).
- `REPEAT_PERIOD`, 24'd1_500_000: interval between later auto-repeat steps (macro only).

Ports:
- `i_clk`, input, 1: system/audio clock.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_valid`, input, 1: new-sample strobe, one cycle wide.
- `i_key_sel`, input, 1: debounced select key, level, active-high.
- `i_key_up`, input, 1: debounced increment key, level.
- `i_key_down`, input, 1: debounced decrement key, level.
- `i_sw_en`, input, NUM_FX: asynchronous effect-enable switches.
- `o_sel`, output, $clog2(NUM_FX): effect currently selected for editing.
- `o_editing`, output, 1: high while the FSM is in EDIT.
- `o_level_cur`, output, 3: shadow level of the selected effect, for the display.
- `o_level`, output, NUM_FX×3: committed levels; effect k uses bits [3k+2:3k].
- `o_enable`, output, NUM_FX: committed enables.

## Operation
- Keys: each key is registered once; press = key & ~key_q.
- `i_sw_en` goes through a 2-flop synchronizer.
- The FSM has two states, IDLE and EDIT.
- IDLE:
  - `o_editing`=0.
  - sel press → EDIT; `o_sel` is unchanged.
  - up/down presses are ignored.
- EDIT:
  - `o_editing`=1.
  - sel press → `o_sel` = (`o_sel`+1) mod NUM_FX, wrapping from NUM_FX-1 to 0.
  - up press → shadow[`o_sel`] saturating +1, maximum 7.
  - down press → shadow[`o_sel`] saturating −1, minimum 0.
  - Every accepted step or sel press reloads the idle counter to 0.
  - Counter = TIMEOUT_CYCLES-1 → IDLE. Shadows are kept.
- Simultaneous events:
  - up and down pressed in the same cycle: both ignored, counter not reloaded.
  - sel together with up/down: sel is handled, up/down ignored.
- Commit: in every cycle with `i_valid`=1, `o_level` ← all shadows and `o_enable` ← synchronized switches. This happens in both states.
- `o_level_cur` = shadow[`o_sel`], combinational.
- Reset (async, any state, including mid-edit): state=IDLE, `o_sel`=0, all shadows=0, `o_level`=0, `o_enable`=0, synchronizer and key registers=0, counters=0, `o_editing`=0, `o_level_cur`=0.

## Timing
- Key edge: key first sampled high at edge n → shadow/`o_sel`/state updated at edge n+1 → `o_level_cur` valid after n+1.
- Commit: `o_level` takes the shadow value present before the `i_valid` edge. Total latency from key to `o_level` is 2 cycles plus the wait for the next `i_valid`.
- Switch: `i_sw_en` to the synchronized value takes 2 cycles; `o_enable` updates on the first `i_valid` after that.
- Timeout: exactly TIMEOUT_CYCLES cycles after the last accepted event, `o_editing` falls.
- A held key produces one press only. Re-pressing requires key_q=0 for at least 1 cycle.

## Configuration
- `EFFECT_CTRL_AUTOREPEAT_EN` defined, in EDIT with up XOR down held:
  - after REPEAT_DELAY cycles from the press, one extra step;
  - then one step every REPEAT_PERIOD cycles;
  - saturation still applies;
  - each repeat step reloads the idle counter;
  - releasing the key or pressing both clears the repeat counter.
- Undefined: one step per press; the repeat counter logic and REPEAT_* parameters are unused.

## Structure
- Package `effect_ctrl_pkg`:
  - `LVL_W`=3;
  - `LVL_MAX`=3'd7;
  - default `NUM_FX`;
  - typedef enum `ctrl_state_t` {IDLE, EDIT}.
- Sub-module `key_press_gen`:
  - per-key register, edge detect and optional repeat counter;
  - outputs a one-cycle `step` pulse;
  - instanced for sel (repeat disabled) and for up/down.

## Test plan
All scenarios use NUM_FX=4, TIMEOUT_CYCLES=16, REPEAT_DELAY=8, REPEAT_PERIOD=4, and `i_valid` every 5 cycles.

- Reset check: assert `i_rst` mid-EDIT with shadow[2]=5 → all outputs 0 asynchronously; after release, state IDLE and shadow[2]=0.
- Edit and commit: sel, then up×3 → `o_sel`=0, `o_level_cur`=3; `o_level`[2:0]=3 only at the next `i_valid`; up in IDLE before the sel changes nothing.
- Wrap and saturation:
  - sel×5 → `o_sel`=0,1,2,3,0.
  - up×9 on effect 3 → level 7.
  - down×9 → 0, with no wraparound.
- Simultaneous events:
  - up+down pressed together → no change.
  - sel+up together → `o_sel` increments, level unchanged.
- Timeout: last press at cycle t → `o_editing`=0 at t+17; a press at t+10 extends it to t+27.
- Switches and macro:
  - `i_sw_en`=4'b1010 toggled between strobes → `o_enable`=4'b1010 at the first `i_valid` ≥2 cycles later.
  - With `EFFECT_CTRL_AUTOREPEAT_EN`, holding up for 20 cycles → level 1 + steps at +8, +12, +16, +20 → 5.
  - Without the macro, the same hold gives level 1.
